imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 19 +
 rtl/imem_arbiter_if.sv | 48 ++++
 rtl/imem_arb_pick.sv | 51 +++++
 rtl/imem_arbiter.sv | 128 ++++++++++++
 tb/tb_imem_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter slice.
// Ownership and FSM encodings are used by the top level, the picker and the bench.
package imem_arbiter_pkg;

    localparam int IMEM_DATA_W = 64;
    localparam int IMEM_DEPTH  = 1025;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } owner_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and memory-side signals of the arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface imem_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              fetch_req;
    logic [DATA_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rsp_valid;
    logic [DATA_W-1:0] fetch_rsp_data;
    logic              fetch_rsp_err;

    logic              load_req;
    logic [DATA_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_gnt;
    logic              load_rsp_valid;
    logic              load_rsp_err;

    logic              mem_enable;
    logic              mem_read;
    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    logic              busy;

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_req, load_addr, load_data,
        input  mem_data_out,
        output fetch_gnt, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        output load_gnt, load_rsp_valid, load_rsp_err,
        output mem_enable, mem_read, mem_address, mem_data_in,
        output busy
    );

    modport master (
        output fetch_req, fetch_addr,
        output load_req, load_addr, load_data,
        output mem_data_out,
        input  fetch_gnt, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        input  load_gnt, load_rsp_valid, load_rsp_err,
        input  mem_enable, mem_read, mem_address, mem_data_in,
        input  busy
    );

endinterface

// File: rtl/imem_arb_pick.sv
// Winner selection between fetch and loader requests.
// IMEM_ARB_RR_EN defined: round-robin on ties; otherwise the loader wins every tie.
module imem_arb_pick
    import imem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   fetch_req,
    input  logic   load_req,
    input  logic   take,
    output logic   any_req,
    output owner_t winner
);

`ifdef IMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic prefer_fetch_reg;
    logic prefer_fetch_next;
    logic tie_to_fetch;

    always_comb begin
        tie_to_fetch      = RR_EN ? prefer_fetch_reg : 1'b0;
        any_req           = fetch_req | load_req;
        winner            = OWN_LOAD;
        prefer_fetch_next = prefer_fetch_reg;

        if (fetch_req && load_req) begin
            winner = tie_to_fetch ? OWN_FETCH : OWN_LOAD;
        end else if (fetch_req) begin
            winner = OWN_FETCH;
        end

        // After a grant the other requester gets the next tie.
        if (take) begin
            prefer_fetch_next = (winner == OWN_LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_fetch_reg <= 1'b1;
        end else begin
            prefer_fetch_reg <= prefer_fetch_next;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter in front of a single-port instruction memory.
// Optional round-robin ties via IMEM_ARB_RR_EN (fixed loader priority by default).
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input logic           clk,
    input logic           rst_n,
    imem_arbiter_if.slave bus
);

    state_t            state_reg, state_next;
    owner_t            owner_reg, owner_next;
    logic [DATA_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              read_reg, read_next;
    logic              err_reg, err_next;
    logic              run_reg;

    logic              any_req;
    logic              take;
    owner_t            winner;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] resp_word;
    logic              in_issue;
    logic              in_resp;
    logic              fetch_rsp_valid_w;
    logic              load_rsp_valid_w;

    imem_arb_pick u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (bus.fetch_req),
        .load_req  (bus.load_req),
        .take      (take),
        .any_req   (any_req),
        .winner    (winner)
    );

    assign req_addr  = (winner == OWN_LOAD) ? bus.load_addr : bus.fetch_addr;
    assign resp_word = err_reg ? '0 : bus.mem_data_out;

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        read_next     = read_reg;
        err_next      = err_reg;
        rsp_data_next = rsp_data_reg;
        take          = 1'b0;

        case (state_reg)
            IDLE: begin
                // run_reg keeps grants off while reset is asserted or just released.
                if (run_reg && any_req) begin
                    take       = 1'b1;
                    owner_next = winner;
                    addr_next  = req_addr;
                    read_next  = (winner == OWN_FETCH);
                    data_next  = (winner == OWN_LOAD) ? bus.load_data : '0;
                    err_next   = (req_addr >= DATA_W'(DEPTH));
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                if (owner_reg == OWN_FETCH) begin
                    rsp_data_next = resp_word;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= OWN_FETCH;
            addr_reg     <= '0;
            data_reg     <= '0;
            read_reg     <= 1'b1;
            err_reg      <= 1'b0;
            rsp_data_reg <= '0;
            run_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            read_reg     <= read_next;
            err_reg      <= err_next;
            rsp_data_reg <= rsp_data_next;
            run_reg      <= 1'b1;
        end
    end

    assign in_issue          = (state_reg == ISSUE);
    assign in_resp           = (state_reg == RESP);
    assign fetch_rsp_valid_w = in_resp && (owner_reg == OWN_FETCH);
    assign load_rsp_valid_w  = in_resp && (owner_reg == OWN_LOAD);

    assign bus.fetch_gnt       = take && (winner == OWN_FETCH);
    assign bus.load_gnt        = take && (winner == OWN_LOAD);

    // Out-of-range accesses still walk through ISSUE but never touch the memory.
    assign bus.mem_enable      = in_issue && !err_reg;
    assign bus.mem_read        = in_issue ? read_reg : 1'b1;
    assign bus.mem_address     = in_issue ? addr_reg : '0;
    assign bus.mem_data_in     = in_issue ? data_reg : '0;

    assign bus.fetch_rsp_valid = fetch_rsp_valid_w;
    assign bus.fetch_rsp_err   = fetch_rsp_valid_w && err_reg;
    assign bus.fetch_rsp_data  = fetch_rsp_valid_w ? resp_word : rsp_data_reg;
    assign bus.load_rsp_valid  = load_rsp_valid_w;
    assign bus.load_rsp_err    = load_rsp_valid_w && err_reg;

    assign bus.busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a registered-read memory model.
// Inputs are driven on the falling edge and outputs sampled 1ns later.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DW-1:0] mem [0:2047];

    always #5 clk = ~clk;

    imem_arbiter_if #(.DATA_W(DW)) bus ();

    imem_arbiter #(.DATA_W(DW), .DEPTH(1025)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.mem_enable) begin
            if (bus.mem_read) bus.mem_data_out <= mem[bus.mem_address[10:0]];
            else              mem[bus.mem_address[10:0]] <= bus.mem_data_in;
        end
    end

    task automatic test_reset();
        bus.fetch_req = 1'b1; bus.load_req = 1'b1;
        bus.fetch_addr = 64'd3; bus.load_addr = 64'd4; bus.load_data = '0;
        @(negedge clk); #1;
        n_cmp++; if (bus.fetch_gnt !== 1'b0) begin n_err++; $display("FAIL reset fetch_gnt: got %b want 0", bus.fetch_gnt); end
        n_cmp++; if (bus.load_gnt !== 1'b0) begin n_err++; $display("FAIL reset load_gnt: got %b want 0", bus.load_gnt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mem_enable !== 1'b0) begin n_err++; $display("FAIL reset mem_enable: got %b want 0", bus.mem_enable); end
        n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL reset mem_read: got %b want 1", bus.mem_read); end
        n_cmp++; if (bus.mem_address !== 64'd0) begin n_err++; $display("FAIL reset mem_address: got %h want 0", bus.mem_address); end
        n_cmp++; if (bus.fetch_rsp_data !== 64'd0) begin n_err++; $display("FAIL reset fetch_rsp_data: got %h want 0", bus.fetch_rsp_data); end
        n_cmp++; if ((bus.fetch_rsp_valid | bus.load_rsp_valid) !== 1'b0) begin n_err++; $display("FAIL reset rsp_valid: got %b%b want 00", bus.fetch_rsp_valid, bus.load_rsp_valid); end
        bus.fetch_req = 1'b0; bus.load_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_load();
        @(negedge clk);
        bus.load_req = 1'b1; bus.load_addr = 64'd5; bus.load_data = 64'hDEAD_BEEF; #1;
        n_cmp++; if (bus.load_gnt !== 1'b1) begin n_err++; $display("FAIL load gnt N: got %b want 1", bus.load_gnt); end
        n_cmp++; if (bus.fetch_gnt !== 1'b0) begin n_err++; $display("FAIL load fetch_gnt N: got %b want 0", bus.fetch_gnt); end
        @(negedge clk); bus.load_req = 1'b0; #1;
        n_cmp++; if (bus.mem_enable !== 1'b1) begin n_err++; $display("FAIL load mem_enable N+1: got %b want 1", bus.mem_enable); end
        n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL load mem_read N+1: got %b want 0", bus.mem_read); end
        n_cmp++; if (bus.mem_address !== 64'd5) begin n_err++; $display("FAIL load mem_address N+1: got %h want 5", bus.mem_address); end
        n_cmp++; if (bus.mem_data_in !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL load mem_data_in N+1: got %h want deadbeef", bus.mem_data_in); end
        n_cmp++; if (bus.load_gnt !== 1'b0) begin n_err++; $display("FAIL load gnt N+1: got %b want 0", bus.load_gnt); end
        @(negedge clk); #1;
        n_cmp++; if (bus.load_rsp_valid !== 1'b1) begin n_err++; $display("FAIL load rsp_valid N+2: got %b want 1", bus.load_rsp_valid); end
        n_cmp++; if (bus.load_rsp_err !== 1'b0) begin n_err++; $display("FAIL load rsp_err N+2: got %b want 0", bus.load_rsp_err); end
        n_cmp++; if (bus.fetch_rsp_valid !== 1'b0) begin n_err++; $display("FAIL load fetch_rsp_valid N+2: got %b want 0", bus.fetch_rsp_valid); end
        n_cmp++; if (bus.mem_enable !== 1'b0) begin n_err++; $display("FAIL load mem_enable N+2: got %b want 0", bus.mem_enable); end
        @(negedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL load busy N+3: got %b want 0", bus.busy); end
        $display("load: addr=5 data=deadbeef");
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = 64'd5; #1;
        n_cmp++; if (bus.fetch_gnt !== 1'b1) begin n_err++; $display("FAIL fetch gnt N: got %b want 1", bus.fetch_gnt); end
        @(negedge clk); bus.fetch_req = 1'b0; #1;
        n_cmp++; if (bus.mem_enable !== 1'b1 || bus.mem_read !== 1'b1) begin n_err++; $display("FAIL fetch en/read N+1: got %b%b want 11", bus.mem_enable, bus.mem_read); end
        @(negedge clk); #1;
        n_cmp++; if (bus.fetch_rsp_valid !== 1'b1) begin n_err++; $display("FAIL fetch rsp_valid N+2: got %b want 1", bus.fetch_rsp_valid); end
        n_cmp++; if (bus.fetch_rsp_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL fetch rsp_data N+2: got %h want deadbeef", bus.fetch_rsp_data); end
        n_cmp++; if (bus.fetch_rsp_err !== 1'b0) begin n_err++; $display("FAIL fetch rsp_err N+2: got %b want 0", bus.fetch_rsp_err); end
        @(negedge clk); #1;
        n_cmp++; if (bus.fetch_rsp_valid !== 1'b0) begin n_err++; $display("FAIL fetch rsp_valid N+3: got %b want 0", bus.fetch_rsp_valid); end
        n_cmp++; if (bus.fetch_rsp_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL fetch data hold: got %h want deadbeef", bus.fetch_rsp_data); end
        $display("fetch: addr=5 data=%h", bus.fetch_rsp_data);
    endtask

    task automatic test_out_of_range();
        logic        is_load [3] = '{1'b0, 1'b1, 1'b0};
        logic [DW-1:0] addrs [3] = '{64'd1025, 64'd1025, 64'd1024};
        logic        exp_err [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (is_load[i]) begin bus.load_req = 1'b1; bus.load_addr = addrs[i]; bus.load_data = 64'h55; end
            else begin bus.fetch_req = 1'b1; bus.fetch_addr = addrs[i]; end
            #1;
            n_cmp++; if ((is_load[i] ? bus.load_gnt : bus.fetch_gnt) !== 1'b1) begin n_err++; $display("FAIL oor[%0d] gnt: got 0 want 1", i); end
            @(negedge clk); bus.fetch_req = 1'b0; bus.load_req = 1'b0; #1;
            n_cmp++; if (bus.mem_enable !== !exp_err[i]) begin n_err++; $display("FAIL oor[%0d] mem_enable: got %b want %b", i, bus.mem_enable, !exp_err[i]); end
            @(negedge clk); #1;
            if (is_load[i]) begin
                n_cmp++; if (bus.load_rsp_valid !== 1'b1 || bus.load_rsp_err !== exp_err[i]) begin n_err++; $display("FAIL oor[%0d] load valid/err: got %b%b want 1%b", i, bus.load_rsp_valid, bus.load_rsp_err, exp_err[i]); end
            end else begin
                n_cmp++; if (bus.fetch_rsp_valid !== 1'b1 || bus.fetch_rsp_err !== exp_err[i]) begin n_err++; $display("FAIL oor[%0d] fetch valid/err: got %b%b want 1%b", i, bus.fetch_rsp_valid, bus.fetch_rsp_err, exp_err[i]); end
                n_cmp++; if (bus.fetch_rsp_data !== 64'd0) begin n_err++; $display("FAIL oor[%0d] fetch data: got %h want 0", i, bus.fetch_rsp_data); end
            end
            $display("oor: load=%0b addr=%0d err=%0b", is_load[i], addrs[i], exp_err[i]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic busy_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic gnt_exp  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = 64'd5;
        for (int t = 0; t < 7; t++) begin
            if (t == 4) bus.fetch_req = 1'b0;
            #1;
            n_cmp++; if (bus.fetch_gnt !== gnt_exp[t]) begin n_err++; $display("FAIL b2b gnt t=%0d: got %b want %b", t, bus.fetch_gnt, gnt_exp[t]); end
            n_cmp++; if (bus.busy !== busy_exp[t]) begin n_err++; $display("FAIL b2b busy t=%0d: got %b want %b", t, bus.busy, busy_exp[t]); end
            $display("b2b: t=%0d gnt=%b busy=%b", t, bus.fetch_gnt, bus.busy);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = 64'd5; #1;
        n_cmp++; if (bus.fetch_gnt !== 1'b1) begin n_err++; $display("FAIL abort gnt: got %b want 1", bus.fetch_gnt); end
        @(negedge clk); bus.fetch_req = 1'b0; #1;
        n_cmp++; if (bus.mem_enable !== 1'b1) begin n_err++; $display("FAIL abort issue mem_enable: got %b want 1", bus.mem_enable); end
        #1 rst_n = 1'b0; #1;
        n_cmp++; if (bus.mem_enable !== 1'b0) begin n_err++; $display("FAIL abort mem_enable: got %b want 0", bus.mem_enable); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL abort mem_read: got %b want 1", bus.mem_read); end
        n_cmp++; if (bus.mem_address !== 64'd0) begin n_err++; $display("FAIL abort mem_address: got %h want 0", bus.mem_address); end
        n_cmp++; if (bus.fetch_rsp_data !== 64'd0) begin n_err++; $display("FAIL abort fetch_rsp_data: got %h want 0", bus.fetch_rsp_data); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.fetch_rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL abort post t=%0d: valid=%b busy=%b want 0 0", t, bus.fetch_rsp_valid, bus.busy); end
        end
        $display("reset_abort: idle after release busy=%b", bus.busy);
    endtask

    task automatic test_arbitration();
        owner_t exp_order [4];
        int     got = 0;
`ifdef IMEM_ARB_RR_EN
        exp_order = '{OWN_FETCH, OWN_LOAD, OWN_FETCH, OWN_LOAD};
`else
        exp_order = '{OWN_LOAD, OWN_LOAD, OWN_LOAD, OWN_LOAD};
`endif
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = 64'd5;
        bus.load_req = 1'b1; bus.load_addr = 64'd7; bus.load_data = 64'h1234;
        for (int c = 0; c < 40; c++) begin
            #1;
            n_cmp++; if ((bus.fetch_gnt & bus.load_gnt) !== 1'b0 || (bus.fetch_rsp_valid & bus.load_rsp_valid) !== 1'b0) begin n_err++; $display("FAIL arb exclusive c=%0d: gnt=%b%b rsp=%b%b", c, bus.fetch_gnt, bus.load_gnt, bus.fetch_rsp_valid, bus.load_rsp_valid); end
            if (bus.fetch_gnt === 1'b1 || bus.load_gnt === 1'b1) begin
                n_cmp++; if ((bus.load_gnt === 1'b1 ? OWN_LOAD : OWN_FETCH) !== exp_order[got]) begin n_err++; $display("FAIL arb order[%0d]: got load=%b want load=%b", got, bus.load_gnt, exp_order[got]); end
                $display("arb: grant %0d load=%b", got, bus.load_gnt);
                got++;
            end
            if (got == 4) break;
            @(negedge clk);
        end
        n_cmp++; if (got != 4) begin n_err++; $display("FAIL arb grant count: got %0d want 4", got); end
        @(negedge clk); bus.fetch_req = 1'b0; bus.load_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        bus.load_req = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        test_reset();
        test_load();
        test_fetch();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        test_arbitration();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
